// File: rtl/pipe_pkg.sv
// Shared definitions for the decode/execute boundary: packed control bundle
// layout, memtoreg encodings and the source-operand usage helpers.
package pipe_pkg;

    // Width of the packed decoder control bundle.
    localparam int CTRL_W = 21;

    // Bit offsets of each field inside the control bundle.
    localparam int ALUSRC_BIT   = 0;
    localparam int ALUOP_LSB    = 1;
    localparam int ALUOP_MSB    = 3;
    localparam int MEMTOREG_LSB = 4;
    localparam int MEMTOREG_MSB = 5;
    localparam int MEM_WR_BIT   = 6;
    localparam int BNE_BIT      = 7;
    localparam int BRA_BIT      = 8;
    localparam int REG_WR_BIT   = 9;
    localparam int REG_DST_BIT  = 10;
    localparam int SD_BIT       = 11;
    localparam int WMASK_LSB    = 12;
    localparam int WMASK_MSB    = 19;
    localparam int JUMP_BIT     = 20;

    // Writeback source selector: load data from memory.
    localparam logic [1:0] MEMTOREG_MEM = 2'b01;

    // Packed view of the bundle, MSB first, matching the offsets above.
    typedef struct packed {
        logic       jump;      // [20]
        logic [7:0] wmask;     // [19:12]
        logic       sd;        // [11]
        logic       reg_dst;   // [10]
        logic       reg_wr;    // [9]
        logic       bra;       // [8]
        logic       bne;       // [7]
        logic       mem_wr;    // [6]
        logic [1:0] memtoreg;  // [5:4]
        logic [2:0] alu_op;    // [3:1]
        logic       alu_src;   // [0]
    } ctrl_t;

    // NOP bundle: no register write, no store, no branch, no jump, no mask.
    localparam ctrl_t CTRL_NOP = '0;

    // JAL (jump with register-free target) is the only encoding that ignores rs1.
    function automatic logic src_uses_rs1(input logic jump, input logic alu_src);
        return !(jump && !alu_src);
    endfunction

    // rs2 is read by register-register ops and by stores (store data).
    function automatic logic src_uses_rs2(input logic alu_src, input logic sd);
        return !alu_src || sd;
    endfunction

endpackage

// File: rtl/hazard_detect.sv
// Combinational load-use detector: a load in EX whose destination feeds the
// instruction sitting in decode cannot be forwarded in time, so decode must
// wait one cycle.
module hazard_detect
    import pipe_pkg::*;
(
    input  logic       id_valid_i,
    input  logic [4:0] id_rs1_idx_i,
    input  logic [4:0] id_rs2_idx_i,
    input  logic       id_jump_i,
    input  logic       id_alu_src_i,
    input  logic       id_sd_i,
    input  logic       ex_valid_i,
    input  logic       ex_reg_wr_i,
    input  logic [1:0] ex_memtoreg_i,
    input  logic [4:0] ex_rd_idx_i,
    input  logic       flush_i,
    input  logic       hold_i,
    output logic       load_use_stall_o
);

    logic uses_rs1;
    logic uses_rs2;
    logic ex_is_load;
    logic rs1_hit;
    logic rs2_hit;

    // Decide whether decode depends on a pending load result; flush and hold
    // override because neither lets the stalled instruction advance anyway.
    always_comb begin
        uses_rs1   = src_uses_rs1(id_jump_i, id_alu_src_i);
        uses_rs2   = src_uses_rs2(id_alu_src_i, id_sd_i);
        ex_is_load = ex_valid_i && ex_reg_wr_i && (ex_memtoreg_i == MEMTOREG_MEM);
        rs1_hit    = uses_rs1 && (id_rs1_idx_i == ex_rd_idx_i);
        rs2_hit    = uses_rs2 && (id_rs2_idx_i == ex_rd_idx_i);
        load_use_stall_o = id_valid_i && ex_is_load && (ex_rd_idx_i != 5'd0)
                           && (rs1_hit || rs2_hit)
                           && !flush_i && !hold_i;
    end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register. Captures decode results every cycle, turns a
// load-use dependency into a one-cycle bubble (stalling PC and IF/ID), kills
// its contents on an EX-resolved redirect, freezes on a global hold and
// counts inserted load-use bubbles with a saturating counter.
//
// Valid semantics: ex_valid_o marks a real instruction in EX. A bubble always
// carries the NOP control bundle, so an invalid slot can never write a
// register, store, branch or jump even if a consumer ignores ex_valid_o.
module id_ex_stage
    import pipe_pkg::*;
#(
    parameter int XLEN  = 64,
    parameter int CNT_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              id_valid_i,
    input  logic [XLEN-1:0]   id_pc_i,
    input  logic [4:0]        id_rs1_idx_i,
    input  logic [4:0]        id_rs2_idx_i,
    input  logic [4:0]        id_rd_idx_i,
    input  logic [XLEN-1:0]   id_rs1_data_i,
    input  logic [XLEN-1:0]   id_rs2_data_i,
    input  logic [XLEN-1:0]   id_imm_i,
    input  logic [CTRL_W-1:0] id_ctrl_i,
    input  logic              flush_i,
    input  logic              hold_i,
    output logic              ex_valid_o,
    output logic [XLEN-1:0]   ex_pc_o,
    output logic [XLEN-1:0]   ex_rs1_data_o,
    output logic [XLEN-1:0]   ex_rs2_data_o,
    output logic [XLEN-1:0]   ex_imm_o,
    output logic [4:0]        ex_rs1_idx_o,
    output logic [4:0]        ex_rs2_idx_o,
    output logic [4:0]        ex_rd_idx_o,
    output logic [CTRL_W-1:0] ex_ctrl_o,
    output logic              load_use_stall_o,
    output logic [CNT_W-1:0]  bubble_cnt_o
);

    ctrl_t             id_ctrl;
    ctrl_t             ex_ctrl_q;
    logic              ex_valid_q;
    logic [XLEN-1:0]   ex_pc_q;
    logic [XLEN-1:0]   ex_rs1_data_q;
    logic [XLEN-1:0]   ex_rs2_data_q;
    logic [XLEN-1:0]   ex_imm_q;
    logic [4:0]        ex_rs1_idx_q;
    logic [4:0]        ex_rs2_idx_q;
    logic [4:0]        ex_rd_idx_q;
    logic [CNT_W-1:0]  bubble_cnt_q;
    logic              stall;

    assign id_ctrl = ctrl_t'(id_ctrl_i);

    hazard_detect u_hazard_detect (
        .id_valid_i       (id_valid_i),
        .id_rs1_idx_i     (id_rs1_idx_i),
        .id_rs2_idx_i     (id_rs2_idx_i),
        .id_jump_i        (id_ctrl.jump),
        .id_alu_src_i     (id_ctrl.alu_src),
        .id_sd_i          (id_ctrl.sd),
        .ex_valid_i       (ex_valid_q),
        .ex_reg_wr_i      (ex_ctrl_q.reg_wr),
        .ex_memtoreg_i    (ex_ctrl_q.memtoreg),
        .ex_rd_idx_i      (ex_rd_idx_q),
        .flush_i          (flush_i),
        .hold_i           (hold_i),
        .load_use_stall_o (stall)
    );

    // Pipeline register update: flush, then hold, then load-use bubble, then capture.
    // The stall term is already masked by flush/hold, so the order only
    // matters for flush versus hold.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_valid_q    <= 1'b0;
            ex_pc_q       <= '0;
            ex_rs1_data_q <= '0;
            ex_rs2_data_q <= '0;
            ex_imm_q      <= '0;
            ex_rs1_idx_q  <= '0;
            ex_rs2_idx_q  <= '0;
            ex_rd_idx_q   <= '0;
            ex_ctrl_q     <= CTRL_NOP;
        end else if (flush_i || (!hold_i && stall)) begin
            ex_valid_q    <= 1'b0;
            ex_pc_q       <= '0;
            ex_rs1_data_q <= '0;
            ex_rs2_data_q <= '0;
            ex_imm_q      <= '0;
            ex_rs1_idx_q  <= '0;
            ex_rs2_idx_q  <= '0;
            ex_rd_idx_q   <= '0;
            ex_ctrl_q     <= CTRL_NOP;
        end else if (!hold_i) begin
            ex_valid_q    <= id_valid_i;
            ex_pc_q       <= id_pc_i;
            ex_rs1_data_q <= id_rs1_data_i;
            ex_rs2_data_q <= id_rs2_data_i;
            ex_imm_q      <= id_imm_i;
            ex_rs1_idx_q  <= id_rs1_idx_i;
            ex_rs2_idx_q  <= id_rs2_idx_i;
            ex_rd_idx_q   <= id_rd_idx_i;
            ex_ctrl_q     <= id_valid_i ? id_ctrl : CTRL_NOP;
        end
    end

    // Saturating count of load-use bubbles; a flush bubble is not counted.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bubble_cnt_q <= '0;
        end else if (stall && (bubble_cnt_q != {CNT_W{1'b1}})) begin
            bubble_cnt_q <= bubble_cnt_q + 1'b1;
        end
    end

    assign ex_valid_o       = ex_valid_q;
    assign ex_pc_o          = ex_pc_q;
    assign ex_rs1_data_o    = ex_rs1_data_q;
    assign ex_rs2_data_o    = ex_rs2_data_q;
    assign ex_imm_o         = ex_imm_q;
    assign ex_rs1_idx_o     = ex_rs1_idx_q;
    assign ex_rs2_idx_o     = ex_rs2_idx_q;
    assign ex_rd_idx_o      = ex_rd_idx_q;
    assign ex_ctrl_o        = ex_ctrl_q;
    assign load_use_stall_o = stall;
    assign bubble_cnt_o     = bubble_cnt_q;

endmodule

// File: doc/id_ex_stage.md
Name: id_ex_stage

Overview:
- Pipeline register between decode (control decoder, register file, immediate generator) and execute.
- Captures the decoded control bundle, operands, immediate, PC and register indices each cycle.
- Detects load-use hazards and inserts a bubble while asserting a stall to the PC/IF-ID stage.
- Supports EX-resolved branch/jump flush, global hold, and a bubble performance counter.

Parameters:
- XLEN, 64, datapath/PC width.
- CTRL_W, 21, width of packed control bundle (see Decomposition).
- CNT_W, 32, bubble counter width.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- id_valid_i  in  1  decode slot holds a real instruction
- id_pc_i  in  XLEN  PC of decode instruction
- id_rs1_idx_i, id_rs2_idx_i, id_rd_idx_i  in  5 each  register indices (instr[19:15], [24:20], [11:7])
- id_rs1_data_i, id_rs2_data_i  in  XLEN each  register file read data
- id_imm_i  in  XLEN  sign-extended immediate
- id_ctrl_i  in  CTRL_W  packed decoder outputs
- flush_i  in  1  EX taken branch/jump; kill decode and ID/EX contents
- hold_i  in  1  freeze the whole pipe (memory stall)
- ex_valid_o  out  1  EX slot valid
- ex_pc_o, ex_rs1_data_o, ex_rs2_data_o, ex_imm_o  out  XLEN each  registered copies
- ex_rs1_idx_o, ex_rs2_idx_o, ex_rd_idx_o  out  5 each  registered indices (to forwarding unit)
- ex_ctrl_o  out  CTRL_W  registered control bundle
- load_use_stall_o  out  1  combinational: hold PC and IF/ID this cycle
- bubble_cnt_o  out  CNT_W  count of inserted load-use bubbles

Behaviour:
- Reset (rst_n low, async): all ex_* outputs 0, ex_ctrl_o = 0 (NOP bundle: no reg_wr, mem_wr, bra, jump, sd; wmask 0), bubble_cnt_o = 0. Deassertion is synchronised externally; first capture is on the first rising edge with rst_n high.
- Latency: 1 cycle, decode to ex_* outputs.
- Source-usage decode (from id_ctrl_i):
  - uses_rs1 = !(jump && !ALUsrc), i.e. JAL does not use rs1.
  - uses_rs2 = !ALUsrc || sd.
- Load in EX: ex_is_load = ex_valid_o && ex_ctrl.reg_wr && ex_ctrl.memtoreg == 2'b01.
- Hazard condition:
  - load_use_stall_o = id_valid_i && ex_is_load && ex_rd_idx_o != 0 && ((uses_rs1 && id_rs1_idx_i == ex_rd_idx_o) || (uses_rs2 && id_rs2_idx_i == ex_rd_idx_o)).
  - Forced 0 when flush_i or hold_i is high.
- Update priority at each rising edge (first matching rule wins):
  1. flush_i: load bubble (ex_valid_o = 0, ex_ctrl_o = 0, data fields 0). No bubble count.
  2. hold_i: retain all registers; counter unchanged.
  3. load_use_stall_o: load bubble; bubble_cnt_o += 1. Decode inputs are presented again next cycle by the held IF/ID stage.
  4. Otherwise: capture all id_* inputs; ex_valid_o = id_valid_i; ex_ctrl_o = id_valid_i ? id_ctrl_i : 0.
- A bubble never asserts reg_wr, mem_wr, bra or jump downstream.
- Back-to-back: exactly one bubble per load-use pair. After the bubble, EX holds a non-load, so the stall drops the next cycle.
- rd = x0 load never stalls.
- Counter saturates at all-ones; it does not wrap.
- Reset mid-stall: outputs go to reset values immediately; stall drops combinationally because ex_valid_o = 0.

Decomposition:
- Shared package pipe_pkg:
  - CTRL_W.
  - Bit offsets of each field: ALUsrc[0], ALUOp[3:1], memtoreg[5:4], mem_wr[6], bne[7], bra[8], reg_wr[9], reg_dst[10], sd[11], wmask[19:12], jump[20].
  - MEMTOREG_MEM = 2'b01.
  - NOP control constant = 0.
- One natural sub-module: hazard_detect (combinational load-use logic), instantiated inside. Registers and counter stay in id_ex_stage.

Test Plan:
- Reset: drive inputs nonzero, pulse rst_n low mid-cycle -> all outputs 0 asynchronously; first edge after release captures id_pc_i = 0x100.
- Pass-through: ADD x3,x1,x2 with rs1 = 5, rs2 = 7, pc = 0x40 -> next cycle ex_valid_o = 1, ex_rs1_data_o = 5, ex_ctrl_o = id_ctrl_i, load_use_stall_o = 0.
- Load-use: LD x5 in EX, then ADD x6,x5,x1 in decode -> load_use_stall_o = 1 for exactly one cycle, ex_valid_o = 0 the next cycle, bubble_cnt_o = 1, then the ADD captured.
- No false stall: LD x0 followed by use of x0 -> no stall. LD x5 followed by ADDI x6,x7 (rs2 field = 5, ALUsrc = 1) -> no stall.
- Flush vs stall: load-use condition with flush_i = 1 -> stall 0, bubble inserted, bubble_cnt_o unchanged.
- Hold: hold_i = 1 for 3 cycles with changing inputs -> outputs frozen; on release, the current input is captured.
